// File: rtl/kalman_pkg.sv
// Shared Q18 fixed-point constants, CORDIC arctangent table and FSM state
// encoding for the sin/cos CORDIC engine.
package kalman_pkg;

   localparam int PI       = 823550;
   localparam int HALF_PI  = 411775;
   localparam int TWO_PI   = 1647099;
   localparam int CORDIC_K = 159188;

   // round(atan(2^-i) * 2^18); entries past i=18 fall below half an LSB
   localparam int ATAN_LUT [0:23] = '{
      205887, 121542, 64220, 32599, 16363, 8189, 4096, 2048,
      1024,   512,    256,   128,   64,    32,   16,   8,
      4,      2,      1,     0,     0,     0,    0,    0
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREP   = 2'd1,
      ROTATE = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-idx) in Q format,
// sign-extended to the CORDIC datapath width.
module cordic_atan_rom
   import kalman_pkg::*;
#(
   parameter int W = 34
) (
   input  logic [4:0]          idx,
   output logic signed [W-1:0] atan
);

   always_comb begin
      atan = '0;
      if (idx < 5'd24) atan = W'(ATAN_LUT[idx]);
   end

endmodule

// File: rtl/sincos_cordic.sv
// Iterative CORDIC sine/cosine: IDLE -> PREP (wrap/fold) -> ITER rotations -> DONE.
// Define SINCOS_ANGLE_WRAP_EN to add a single +/-2pi wrap step ahead of the fold.
module sincos_cordic
   import kalman_pkg::*;
#(
   parameter int N    = 32,
   parameter int Q    = 18,
   parameter int ITER = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] theta,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] stheta,
   output logic [N-1:0] ctheta,
   output logic [N-1:0] theta_o
);

   localparam int W = N + 2;
   localparam logic signed [W-1:0] PI_W       = W'(PI);
   localparam logic signed [W-1:0] N_PI_W     = -W'(PI);
   localparam logic signed [W-1:0] HALF_PI_W  = W'(HALF_PI);
   localparam logic signed [W-1:0] N_HALF_PI_W = -W'(HALF_PI);
   localparam logic signed [W-1:0] K_W        = W'(CORDIC_K);
   localparam logic signed [W-1:0] MAX_W      = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_W      = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};
   localparam logic [N-1:0]        ONE_Q      = {{(N-1){1'b0}}, 1'b1} << Q;
`ifdef SINCOS_ANGLE_WRAP_EN
   localparam logic signed [W-1:0] TWO_PI_W   = W'(TWO_PI);
`endif

   state_e              state_q, state_d;
   logic [N-1:0]        theta_q, theta_d;
   logic [N-1:0]        ang_q, ang_d;
   logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [4:0]          iter_q, iter_d;
   logic                neg_q, neg_d;
   logic                done_q, done_d;
   logic [N-1:0]        stheta_q, stheta_d, ctheta_q, ctheta_d, theta_o_q, theta_o_d;

   logic signed [W-1:0] a_in, a_wrap, a_fold, atan_w, x_fin, y_fin;
   logic                fold_neg;

   function automatic logic [N-1:0] sat(input logic signed [W-1:0] v);
      if (v > MAX_W)      return MAX_W[N-1:0];
      else if (v < MIN_W) return MIN_W[N-1:0];
      else                return v[N-1:0];
   endfunction

   cordic_atan_rom #(.W(W)) u_atan_rom (
      .idx  (iter_q),
      .atan (atan_w)
   );

   // NOTE: every always_comb output gets a default assignment first, so no path can infer a latch.
   always_comb begin
      a_in = {{2{theta_q[N-1]}}, theta_q};
`ifdef SINCOS_ANGLE_WRAP_EN
      if (a_in > PI_W)        a_wrap = a_in - TWO_PI_W;
      else if (a_in < N_PI_W) a_wrap = a_in + TWO_PI_W;
      else                    a_wrap = a_in;
`else
      a_wrap = a_in;
`endif
      a_fold   = a_wrap;
      fold_neg = 1'b0;
      if (a_wrap > HALF_PI_W) begin
         a_fold   = a_wrap - PI_W;
         fold_neg = 1'b1;
      end else if (a_wrap < N_HALF_PI_W) begin
         a_fold   = a_wrap + PI_W;
         fold_neg = 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = PREP;
         PREP:    state_d = ROTATE;
         ROTATE:  if (iter_q == 5'(ITER - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: busy covers the done-pulse cycle, which is already back in IDLE
   always_comb begin
      busy = (state_q != IDLE) || done_q;
      done = done_q;
   end

   assign x_fin = neg_q ? -x_q : x_q;
   assign y_fin = neg_q ? -y_q : y_q;

   always_comb begin
      theta_d   = theta_q;
      ang_d     = ang_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      iter_d    = iter_q;
      neg_d     = neg_q;
      done_d    = 1'b0;
      stheta_d  = stheta_q;
      ctheta_d  = ctheta_q;
      theta_o_d = theta_o_q;
      unique case (state_q)
         IDLE: if (start) theta_d = theta;
         PREP: begin
            ang_d  = a_wrap[N-1:0];
            neg_d  = fold_neg;
            x_d    = K_W;
            y_d    = '0;
            z_d    = a_fold;
            iter_d = '0;
         end
         ROTATE: begin
            if (!z_q[W-1]) begin
               x_d = x_q - (y_q >>> iter_q);
               y_d = y_q + (x_q >>> iter_q);
               z_d = z_q - atan_w;
            end else begin
               x_d = x_q + (y_q >>> iter_q);
               y_d = y_q - (x_q >>> iter_q);
               z_d = z_q + atan_w;
            end
            iter_d = iter_q + 5'd1;
         end
         DONE: begin
            stheta_d  = sat(y_fin);
            ctheta_d  = sat(x_fin);
            theta_o_d = ang_q;
            done_d    = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         theta_q   <= '0;
         ang_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         iter_q    <= '0;
         neg_q     <= 1'b0;
         done_q    <= 1'b0;
         stheta_q  <= '0;
         ctheta_q  <= ONE_Q;
         theta_o_q <= '0;
      end else begin
         state_q   <= state_d;
         theta_q   <= theta_d;
         ang_q     <= ang_d;
         x_q       <= x_d;
         y_q       <= y_d;
         z_q       <= z_d;
         iter_q    <= iter_d;
         neg_q     <= neg_d;
         done_q    <= done_d;
         stheta_q  <= stheta_d;
         ctheta_q  <= ctheta_d;
         theta_o_q <= theta_o_d;
      end
   end

   assign stheta  = stheta_q;
   assign ctheta  = ctheta_q;
   assign theta_o = theta_o_q;

endmodule

// File: tb/tb_sincos_cordic.sv
// Self-checking bench for sincos_cordic: directed vector table, back-to-back,
// mid-operation reset and randomized angles against a real-math sin/cos model.
module tb_sincos_cordic;

   localparam int TOL = 16;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] theta;
   logic        busy;
   logic        done;
   logic [31:0] stheta;
   logic [31:0] ctheta;
   logic [31:0] theta_o;

   int n_checks = 0;
   int n_errors = 0;

   sincos_cordic dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .theta   (theta),
      .busy    (busy),
      .done    (done),
      .stheta  (stheta),
      .ctheta  (ctheta),
      .theta_o (theta_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int th;
      int s;
      int c;
      int o;
   } vec_t;

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_near(input string name, input int act, input int req);
      check(name, (act - req <= TOL) && (req - act <= TOL), act, req);
   endtask

   // Reference: optional single wrap step, then ideal sin/cos of the angle used
   function automatic void model(input int th, output int s, output int c, output int o);
      int  w;
      real r;
      w = th;
`ifdef SINCOS_ANGLE_WRAP_EN
      if (th > 823550)       w = th - 1647099;
      else if (th < -823550) w = th + 1647099;
`endif
      r = real'(w) / 262144.0;
      s = int'($sin(r) * 262144.0);
      c = int'($cos(r) * 262144.0);
      o = w;
   endfunction

   // One isolated request; garbage is driven on theta while busy
   task automatic run_op(input int th, output int lat, output int s, output int c,
                         output int o, output bit held, output bit busy_ok);
      int s0, c0, o0;
      @(negedge clk);
      start = 1'b1;
      theta = th;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      theta   = $urandom;
      busy_ok = busy;
      held    = 1'b1;
      s0 = stheta; c0 = ctheta; o0 = theta_o;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (!done && (stheta != s0 || ctheta != c0 || theta_o != o0)) held = 1'b0;
      end while (!done && lat < 60);
      busy_ok = busy_ok && busy;
      s = $signed(stheta);
      c = $signed(ctheta);
      o = $signed(theta_o);
      @(negedge clk);
      busy_ok = busy_ok && !busy && !done;
   endtask

   initial begin
      vec_t vecs[$];
      int   lat, s, c, o, es, ec, eo, gap;
      bit   held, bok, seen;

      vecs.push_back('{0,       0,       262144,  0});
      vecs.push_back('{411775,  262144,  0,       411775});
      vecs.push_back('{-823550, 0,       -262144, -823550});
      vecs.push_back('{655360,  156884,  -210015, 655360});
      vecs.push_back('{-411775, -262144, 0,       -411775});
      vecs.push_back('{411776,  262144,  0,       411776});
      vecs.push_back('{-411776, -262144, 0,       -411776});
      vecs.push_back('{823550,  0,       -262144, 823550});
      vecs.push_back('{-655360, -156884, -210015, -655360});
`ifdef SINCOS_ANGLE_WRAP_EN
      vecs.push_back('{1048576, -198391, -171345, -598523});
`endif

      reset = 1'b1;
      start = 1'b0;
      theta = '0;
      #1;
      check("rst_busy",    busy == 1'b0, busy, 0);
      check("rst_done",    done == 1'b0, done, 0);
      check("rst_stheta",  stheta == 32'd0, stheta, 0);
      check("rst_ctheta",  ctheta == 32'd262144, ctheta, 262144);
      check("rst_theta_o", theta_o == 32'd0, theta_o, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].th, lat, s, c, o, held, bok);
         check("vec_latency", lat == 18, lat, 18);
         check_near("vec_stheta", s, vecs[i].s);
         check_near("vec_ctheta", c, vecs[i].c);
         check("vec_theta_o", o == vecs[i].o, o, vecs[i].o);
         check("vec_hold", held, held, 1);
         check("vec_busy", bok, bok, 1);
      end

      // start held high: second accept lands on the cycle done falls
      @(negedge clk);
      start = 1'b1;
      theta = 300000;
      @(posedge clk);
      @(negedge clk);
      theta = -500000;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!done && lat < 60);
      check("b2b_first_latency", lat == 18, lat, 18);
      model(300000, es, ec, eo);
      check_near("b2b_first_stheta", $signed(stheta), es);
      check_near("b2b_first_ctheta", $signed(ctheta), ec);
      theta = -200000;
      @(posedge clk);
      @(negedge clk);
      theta = 700000;
      gap = 1;
      while (!done && gap < 60) begin
         @(posedge clk);
         gap++;
         @(negedge clk);
      end
      check("b2b_period", gap == 19, gap, 19);
      model(-200000, es, ec, eo);
      check_near("b2b_second_stheta", $signed(stheta), es);
      check_near("b2b_second_ctheta", $signed(ctheta), ec);
      check("b2b_second_theta_o", $signed(theta_o) == eo, $signed(theta_o), eo);
      start = 1'b0;
      repeat (25) @(negedge clk);

      // reset during ROTATE aborts the request
      run_op(655360, lat, s, c, o, held, bok);
      @(negedge clk);
      start = 1'b1;
      theta = 300000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy",    busy == 1'b0, busy, 0);
      check("abort_done",    done == 1'b0, done, 0);
      check("abort_stheta",  stheta == 32'd0, stheta, 0);
      check("abort_ctheta",  ctheta == 32'd262144, ctheta, 262144);
      check("abort_theta_o", theta_o == 32'd0, theta_o, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", !seen, seen, 0);
      run_op(-300000, lat, s, c, o, held, bok);
      model(-300000, es, ec, eo);
      check("post_reset_latency", lat == 18, lat, 18);
      check_near("post_reset_stheta", s, es);
      check_near("post_reset_ctheta", c, ec);

      for (int k = 0; k < 24; k++) begin
         int th;
`ifdef SINCOS_ANGLE_WRAP_EN
         th = int'($urandom_range(2 * 1647099)) - 1647099;
`else
         th = int'($urandom_range(2 * 823550)) - 823550;
`endif
         model(th, es, ec, eo);
         run_op(th, lat, s, c, o, held, bok);
         check("rand_latency", lat == 18, lat, 18);
         check_near("rand_stheta", s, es);
         check_near("rand_ctheta", c, ec);
         check("rand_theta_o", o == eo, o, eo);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sincos_cordic.md
SINCOS_CORDIC -- requirements
Module: sincos_cordic

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning total signed fixed-point word width.
REQ-002 The block SHALL have parameter Q, default 18, meaning fractional bits; all angles in radians, all values signed Q(N-Q).Q.
REQ-003 The block SHALL have parameter ITER, default 16, meaning CORDIC micro-rotations (range 8..24).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 The block SHALL have port theta  input  N  signed angle, Q format.
REQ-008 The block SHALL have port busy  output  1  high from accepted start until done pulse inclusive.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; stheta/ctheta/theta_o valid.
REQ-010 The block SHALL have ports stheta, ctheta  output  N each  sin/cos of angle, Q format.
REQ-011 The block SHALL have port theta_o  output  N  angle actually used (post-wrap); feeds downstream theta with stheta/ctheta.

Function
REQ-012 FSM SHALL have states IDLE, PREP, ROTATE, DONE; IDLE->PREP on start, PREP->ROTATE, ROTATE->DONE after ITER cycles, DONE->IDLE.
REQ-013 Accept: start=1 in IDLE latches theta that edge; start in any other state SHALL be ignored, no queueing.
REQ-014 PREP SHALL fold angle to [-pi/2, pi/2]: a>pi/2 -> a-pi, negate results; a<-pi/2 -> a+pi, negate results; |a|=pi/2 exactly not folded.
REQ-015 ROTATE SHALL init x=K (159188 at Q=18), y=0, z=folded angle; iteration i: d=sign(z) (z>=0 -> +1), x-=d*(y>>>i), y+=d*(x>>>i), z-=d*atan(2^-i); arithmetic shifts, N-bit wrap-free internal width N+2.
REQ-016 DONE SHALL register stheta=y, ctheta=x (sign-corrected per fold, saturated to N bits), theta_o, and pulse done.
REQ-017 Latency SHALL be exactly ITER+2 cycles from start-accepting edge to edge where done=1; next start accepted earliest the cycle done=1 has fallen (back-to-back period ITER+3).
REQ-018 stheta/ctheta/theta_o SHALL hold last values between done pulses; change only on the done edge.
REQ-019 Accuracy SHALL be within ±16 LSB of ideal sin/cos for ITER=16, Q=18.

Reset
REQ-020 reset SHALL asynchronously force IDLE, busy=0, done=0, stheta=0, ctheta=2^Q, theta_o=0, clear x/y/z/iteration counter.
REQ-021 reset mid-operation SHALL abort; no done pulse for the aborted request; first start after reset release accepted normally.

Configuration
REQ-022 Macro SINCOS_ANGLE_WRAP_EN defined: PREP SHALL first apply one wrap step (a>pi -> a-2pi; a<-pi -> a+2pi) before folding, adding no cycle; theta_o reports wrapped angle.
REQ-023 Macro undefined: no wrap; input SHALL be required within [-pi, pi]; out-of-range results unspecified; theta_o=theta.

Structure
REQ-024 Shared package kalman_pkg SHALL hold Q-format constants PI (823550), HALF_PI (411775), TWO_PI (1647099), CORDIC_K, atan table ATAN_LUT[0:23], and the FSM state enum.
REQ-025 Sub-module cordic_atan_rom SHALL map iteration index to atan(2^-i) combinationally from ATAN_LUT.

Verification
REQ-026 theta=0, start -> after 18 cycles done=1, stheta=0±16, ctheta=262144±16.
REQ-027 theta=411775 (pi/2) -> stheta=262144±16, ctheta=0±16; theta=-823550 (-pi) -> stheta=0±16, ctheta=-262144±16.
REQ-028 theta=2.5 rad (655360) -> stheta=156884±16, ctheta=-210015±16 (fold path).
REQ-029 start held high continuously -> done every 19 cycles; theta changed while busy not used.
REQ-030 reset asserted at cycle 5 of ROTATE -> outputs at reset values immediately, no done pulse; with SINCOS_ANGLE_WRAP_EN, theta=4.0 rad (1048576) -> theta_o=-598523, stheta=-198391±16, ctheta=-171345±16.
